// File: rtl/crc32.sv
// ---------------------------------------------------------------------------
// crc32 - streaming Ethernet CRC-32 engine for the RMII transmit path.
//
// Absorbs one dibit per clock in wire order and continuously presents the
// complemented running checksum. The frame packer serialises axiod as the
// FCS, axiod[31] first.
//
// Ports:
//   clk    in   1   system clock (50 MHz RMII domain), rising edge
//   rst    in   1   synchronous active-high reset; reseeds the CRC
//   axiiv  in   1   input valid; dibit on axiid absorbed this cycle
//   axiid  in   2   input dibit; axiid[0] is the earlier bit on the wire
//   axiov  out  1   registered copy of axiiv (one-cycle delay)
//   axiod  out  32  current checksum, ~crc, driven from the register
//
// Handshake: valid-only stream, no back-pressure. Every cycle with axiiv=1
// transfers one dibit; axiov=1 on the following cycle marks axiod as
// covering that dibit. axiod stays stable while axiiv is low.
// ---------------------------------------------------------------------------
module crc32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        axiiv,
  input  logic [1:0]  axiid,
  output logic        axiov,
  output logic [31:0] axiod
);

  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  // One MSB-first Galois step of the non-reflected polynomial.
  function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
    logic fb;
    fb = c[31] ^ b;
    return {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
  endfunction

  logic [31:0] crc;
  logic [31:0] crc_next;

  // Earlier wire bit (axiid[0]) goes in first.
  always_comb begin
    crc_next = crc_bit(crc_bit(crc, axiid[0]), axiid[1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc   <= SEED;
      axiov <= 1'b0;
    end else begin
      axiov <= axiiv;
      if (axiiv) begin
        crc <= crc_next;
      end
    end
  end

  assign axiod = ~crc;

endmodule

// File: tb/tb_crc32.sv
// ---------------------------------------------------------------------------
// tb_crc32 - scoreboard bench for crc32.
//
// The driver issues one input cycle per negedge and pushes the expected
// {axiov, axiod} for the following cycle into exp_q; the monitor pops and
// compares one entry shortly after every rising edge. The reference model
// keeps the list of absorbed bits since the last reset and recomputes the
// CRC over the whole list. Known-answer constants are checked as well.
// ---------------------------------------------------------------------------
module tb_crc32;

  localparam logic [31:0] POLY = 32'h04C11DB7;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;
  logic        axiiv;
  logic [1:0]  axiid;
  logic        axiov;
  logic [31:0] axiod;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  crc32 dut (
    .clk   (clk),
    .rst   (rst),
    .axiiv (axiiv),
    .axiid (axiid),
    .axiov (axiov),
    .axiod (axiod)
  );

  // ---------------- scoreboard state ----------------
  logic [32:0] exp_q[$];
  bit          model_bits[$];
  int          n_cmp = 0;
  int          n_err = 0;

  logic [7:0]  vec[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: CRC over every bit absorbed since reset, in wire order.
  function automatic logic [31:0] model_crc();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (model_bits[i]) begin
      if (c[31] ^ model_bits[i]) c = {c[30:0], 1'b0} ^ POLY;
      else                       c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [1:0] d, input logic r);
    logic [31:0] e_od;
    logic        e_ov;
    @(negedge clk);
    rst   = r;
    axiiv = v;
    axiid = d;
    if (r) begin
      model_bits.delete();
    end else if (v) begin
      model_bits.push_back(d[0]);
      model_bits.push_back(d[1]);
    end
    e_ov = r ? 1'b0 : v;
    e_od = ~model_crc();
    exp_q.push_back({e_ov, e_od});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'($urandom_range(0, 3)), 1'b0);
  endtask

  // Stream the "123456789" vector, LSB dibit first; optional random gaps.
  task automatic send_vec(input bit gaps);
    logic [7:0] b;
    for (int i = 0; i < 9; i++) begin
      b = vec[i];
      for (int k = 0; k < 4; k++) begin
        if (gaps) begin
          while ($urandom_range(0, 2) == 0) drive(1'b0, 2'($urandom_range(0, 3)), 1'b0);
        end
        drive(1'b1, {b[2*k+1], b[2*k]}, 1'b0);
      end
    end
  endtask

  // Sample axiod after the edge that absorbed the last driven dibit.
  task automatic check_const(input string name, input logic [31:0] req);
    @(posedge clk);
    #2;
    check(name, axiod, req);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [32:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("axiov", {31'd0, axiov}, {31'd0, e[32]});
        check("axiod", axiod, e[31:0]);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] fcs;
    vec = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    rst   = 1'b1;
    axiiv = 1'b0;
    axiid = 2'b00;

    // Reset with axiiv high: dibit must not be absorbed.
    drive(1'b1, 2'b11, 1'b1);
    check_const("reset_axiod", 32'h00000000);

    // Single dibit, then idle: axiov high for exactly one cycle.
    drive(1'b1, 2'b00, 1'b0);
    check_const("single_dibit", 32'h0D4326DA);
    idle(3);

    // Known vector.
    drive(1'b0, 2'b00, 1'b1);
    send_vec(1'b0);
    check_const("vec_123456789", 32'h649C2FD3);
    idle(2);

    // Same vector with random gaps.
    drive(1'b0, 2'b00, 1'b1);
    send_vec(1'b1);
    check_const("vec_gapped", 32'h649C2FD3);
    idle(3);

    // Residue: append the FCS, MSB first, as the packer would.
    fcs = ~model_crc();
    for (int k = 0; k < 32; k += 2) drive(1'b1, {fcs[30-k], fcs[31-k]}, 1'b0);
    check_const("residue", 32'h38FB2284);
    idle(2);

    // Reset mid-stream discards earlier dibits.
    drive(1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b1, 2'($urandom_range(0, 3)), 1'b0);
    drive(1'b1, 2'($urandom_range(0, 3)), 1'b1);
    send_vec(1'b0);
    check_const("vec_after_rst", 32'h649C2FD3);

    // Random traffic with random resets.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 40) == 0));
    end
    idle(3);

    @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/crc32.md
# crc32

Streaming Ethernet CRC-32 engine for the RMII transmit path. It consumes one dibit per clock, in wire order, and continuously presents the complemented running checksum. The frame packer feeds it the transmitted dibits from destination address through payload. It then serialises the result as the FCS, most-significant checksum bit first.

## Interface
Parameters: none (polynomial and seed fixed).

Ports:
- clk  input  1  system clock (50 MHz RMII domain); all logic on rising edge.
- rst  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- axiiv  input  1  input valid; dibit on axiid is absorbed into the CRC this cycle.
- axiid  input  2  input dibit in RMII wire order; axiid[0] is the earlier bit on the wire.
- axiov  output  1  output valid; registered copy of axiiv (one-cycle delay).
- axiod  output  32  current checksum = bitwise complement of the internal CRC register.

## Operation
- Internal state: 32-bit register `crc`.
  - Seed: 0xFFFFFFFF.
  - Polynomial: 0x04C11DB7, non-reflected, MSB-first Galois form.
- Single-bit step for input bit b:
  - fb = crc[31] ^ b
  - crc = {crc[30:0],1'b0} ^ (fb ? 0x04C11DB7 : 0)
- Per valid cycle (axiiv=1), apply two single-bit steps in order: first with b = axiid[0], then with b = axiid[1]. The combined result is registered at the clock edge.
- axiiv=0: crc holds its value; the axiid value is ignored.
- axiod = ~crc, driven combinationally from the register. It therefore reflects all dibits absorbed up to the last edge.
- axiov <= axiiv each cycle.
  - axiod is meaningful whenever axiov=1.
  - axiod remains stable and readable while axiiv is low (the packer reads it during the FCS phase).
- rst=1 has priority over everything: crc <= 0xFFFFFFFF, axiov <= 0.
  - Reset mid-frame discards all accumulated state.
  - Reset is the only way to restart between frames; the packer pulses rst per frame.
- Bit-ordering consequence: bytes fed LSB-first produce axiod equal to the bit-reverse of the standard (reflected) CRC-32.
- Residue: after absorbing a good frame plus its FCS (FCS sent axiod[31] first), crc = 0xC704DD7B, so axiod = 0x38FB2284.

## Timing
- Latency: one cycle. A dibit presented with axiiv=1 at edge N affects crc and axiod after edge N. axiov is high after edge N.
- Throughput: one dibit per clock, no back-pressure, no stalls.
- Reset values:
  - crc = 0xFFFFFFFF.
  - axiod = 0x00000000.
  - axiov = 0.
- rst and axiiv asserted in the same cycle: rst wins; the dibit is not absorbed.
- No counters or length limits; arbitrarily long streams are allowed (no wrap conditions).

## Test plan
- Reset: assert rst for one cycle with axiiv=1 → next cycle axiod=0x00000000, axiov=0.
- Single dibit: reset, then one cycle axiiv=1, axiid=2'b00 → crc=0xF2BCD925, axiod=0x0D4326DA, axiov=1 for exactly one cycle.
- Known vector: reset, then stream ASCII "123456789" (36 dibits, each byte LSB-dibit first, e.g. 0x31 → 01,00,11,00) → axiod=0x649C2FD3 (bit-reverse of 0xCBF43926).
- Gapped input: repeat the previous vector with axiiv randomly deasserted (random axiid on idle cycles) → same final axiod=0x649C2FD3. axiov tracks axiiv delayed by one cycle.
- Residue: stream "123456789", then append the 16 FCS dibits {axiod[30-k],axiod[31-k]} (MSB of each byte first, as the packer sends them) → final axiod=0x38FB2284.
- Reset mid-stream: absorb 10 dibits, assert rst, then stream "123456789" → axiod=0x649C2FD3, unaffected by the earlier dibits.
